// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready fed parallel-to-serial transmitter with an
// optional trailing even-parity bit and gapless back-to-back frames.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int FLEN = WIDTH + (PARITY_EN ? 1 : 0);
  localparam int CW = (FLEN > 1) ? $clog2(FLEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_load_shift;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic             r_par;
  logic             w_par_nxt;
  logic             w_first;
  logic             w_data_bit;
  logic             w_last;
  logic             w_accept;
  logic             w_so;
  logic             w_sv;
  logic             w_fs;
  logic             w_dn;

  assign w_last     = (r_state == SHIFT) && (r_cnt == LAST);
  assign load_ready = (r_state == IDLE) || w_last;
  assign w_accept   = load_valid && load_ready;

  // r_shift holds the bits still to go, next one at the outgoing end
  assign w_first      = LSB_FIRST ? load_data[0] : load_data[WIDTH-1];
  assign w_load_shift = LSB_FIRST ? (load_data >> 1) : (load_data << 1);
  assign w_data_bit   = LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1];

  always_comb begin
    w_state_nxt = IDLE;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = '0;
    w_par_nxt   = r_par;
    w_cnt_inc   = r_cnt + 1'b1;
    w_so        = 1'b0;
    w_sv        = 1'b0;
    w_fs        = 1'b0;
    w_dn        = 1'b0;
    if (w_accept) begin
      w_state_nxt = SHIFT;
      w_shift_nxt = w_load_shift;
      w_par_nxt   = ^load_data;
      w_so        = w_first;
      w_sv        = 1'b1;
      w_fs        = 1'b1;
      w_dn        = (LAST == '0);
    end else if (r_state == SHIFT && !w_last) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = w_cnt_inc;
      w_shift_nxt = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
      w_so        = (PARITY_EN && w_cnt_inc == LAST) ? r_par : w_data_bit;
      w_sv        = 1'b1;
      w_dn        = (w_cnt_inc == LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_par       <= 1'b0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_cnt       <= w_cnt_nxt;
      r_par       <= w_par_nxt;
      ser_out     <= w_so;
      ser_valid   <= w_sv;
      frame_start <= w_fs;
      done        <= w_dn;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: table vectors, hand sequences and a randomized
// frame-queue reference model over three serializer configurations.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v[3];
  logic [7:0] d[3];
  logic       rdy[3];
  logic       so[3];
  logic       sv[3];
  logic       fs[3];
  logic       dn[3];
  logic [3:0] outv[3];

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_a (
    .clk(clk), .rst(rst),
    .load_valid(v[0]), .load_data(d[0]), .load_ready(rdy[0]),
    .ser_out(so[0]), .ser_valid(sv[0]),
    .frame_start(fs[0]), .done(dn[0])
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_b (
    .clk(clk), .rst(rst),
    .load_valid(v[1]), .load_data(d[1]), .load_ready(rdy[1]),
    .ser_out(so[1]), .ser_valid(sv[1]),
    .frame_start(fs[1]), .done(dn[1])
  );

  piso_serializer #(.WIDTH(1), .LSB_FIRST(1'b1), .PARITY_EN(1'b0)) u_c (
    .clk(clk), .rst(rst),
    .load_valid(v[2]), .load_data(d[2][0:0]), .load_ready(rdy[2]),
    .ser_out(so[2]), .ser_valid(sv[2]),
    .frame_start(fs[2]), .done(dn[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_out
    assign outv[g] = {so[g], sv[g], fs[g], dn[g]};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic [3:0] o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(logic vv, logic [7:0] dd, logic rr, logic [3:0] oo);
    vec_t t;
    t.v = vv; t.d = dd; t.rdy = rr; t.o = oo;
    tbl.push_back(t);
  endtask

  // reference model: each accepted word becomes a queue of frame bits
  typedef struct packed {
    logic b;
    logic fs;
    logic dn;
  } rec_t;

  rec_t q[3][$];

  task automatic push_frame(int k, logic [7:0] dat);
    int w;
    int n;
    int ones;
    bit lsb;
    bit par;
    rec_t r;
    w = (k == 2) ? 1 : 8;
    lsb = (k != 1);
    par = (k == 1);
    n = w + (par ? 1 : 0);
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(dat[i]);
    for (int i = 0; i < n; i++) begin
      if (i == w) r.b = ones[0];
      else r.b = lsb ? dat[i] : dat[w-1-i];
      r.fs = (i == 0);
      r.dn = (i == n - 1);
      q[k].push_back(r);
    end
  endtask

  initial begin
    int eb[9];
    bit acc[3];
    rec_t r;
    logic [3:0] e;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0;
      d[k] = 8'h00;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset out%0d", k), outv[k], 4'b0000);
    rst = 1'b0;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset rdy%0d", k), rdy[k], 1'b1);

    // A5 LSB first
    add(1, 8'hA5, 1, 4'b1110);
    add(0, 8'h00, 0, 4'b0100);
    add(0, 8'h00, 0, 4'b1100);
    add(0, 8'h00, 0, 4'b0100);
    add(0, 8'h00, 0, 4'b0100);
    add(0, 8'h00, 0, 4'b1100);
    add(0, 8'h00, 0, 4'b0100);
    add(0, 8'h00, 0, 4'b1101);
    add(0, 8'h00, 1, 4'b0000);
    add(0, 8'h00, 1, 4'b0000);
    // FF then 00 back to back
    add(1, 8'hFF, 1, 4'b1110);
    for (int i = 0; i < 6; i++) add(1, 8'hFF, 0, 4'b1100);
    add(1, 8'hFF, 0, 4'b1101);
    add(1, 8'h00, 1, 4'b0110);
    for (int i = 0; i < 6; i++) add(1, 8'h00, 0, 4'b0100);
    add(1, 8'h00, 0, 4'b0101);
    add(0, 8'h00, 1, 4'b0000);
    // A5 with a 3C pulse while bit 3 is out
    add(1, 8'hA5, 1, 4'b1110);
    add(0, 8'h00, 0, 4'b0100);
    add(0, 8'h00, 0, 4'b1100);
    add(0, 8'h00, 0, 4'b0100);
    add(1, 8'h3C, 0, 4'b0100);
    add(0, 8'h00, 0, 4'b1100);
    add(0, 8'h00, 0, 4'b0100);
    add(0, 8'h00, 0, 4'b1101);
    add(0, 8'h00, 1, 4'b0000);

    foreach (tbl[i]) begin
      v[0] = tbl[i].v;
      d[0] = tbl[i].d;
      chk($sformatf("tbl%0d rdy", i), rdy[0], tbl[i].rdy);
      tick();
      chk($sformatf("tbl%0d out", i), outv[0], tbl[i].o);
    end

    // 81 MSB first with parity
    eb = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 9; i++) begin
      v[1] = (i == 0);
      d[1] = 8'h81;
      if (i == 0) chk("par rdy", rdy[1], 1'b1);
      tick();
      e = {eb[i][0], 1'b1, (i == 0), (i == 8)};
      chk($sformatf("par bit%0d", i), outv[1], e);
    end
    v[1] = 1'b0;
    tick();
    chk("par idle", outv[1], 4'b0000);

    // WIDTH=1 continuous 1,0,1
    v[2] = 1'b1;
    d[2] = 8'h01;
    tick();
    chk("w1 b0", outv[2], 4'b1111);
    d[2] = 8'h00;
    chk("w1 rdy", rdy[2], 1'b1);
    tick();
    chk("w1 b1", outv[2], 4'b0111);
    d[2] = 8'h01;
    tick();
    chk("w1 b2", outv[2], 4'b1111);
    v[2] = 1'b0;
    tick();
    chk("w1 idle", outv[2], 4'b0000);

    // asynchronous reset in the middle of an A5 frame
    v[0] = 1'b1;
    d[0] = 8'hA5;
    tick();
    v[0] = 1'b0;
    tick();
    tick();
    chk("mid sv", sv[0], 1'b1);
    #2 rst = 1'b1;
    #1 chk("async rst", outv[0], 4'b0000);
    tick();
    rst = 1'b0;
    chk("post rst rdy", rdy[0], 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("no residue%0d", i), outv[0], 4'b0000);
    end

    // randomized traffic against the frame-queue model
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        v[k] = ($urandom_range(0, 3) != 0);
        d[k] = 8'($urandom);
        acc[k] = v[k] && (q[k].size() == 0);
        chk($sformatf("rnd%0d rdy%0d", c, k), rdy[k], q[k].size() == 0);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        if (acc[k]) push_frame(k, d[k]);
        if (q[k].size() > 0) begin
          r = q[k].pop_front();
          e = {r.b, 1'b1, r.fs, r.dn};
        end else begin
          e = 4'b0000;
        end
        chk($sformatf("rnd%0d out%0d", c, k), outv[k], e);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
